// File: rtl/sdith_commit_unit.sv
// SDitH per-party commitment engine.
// For each party i it feeds salt || seed_i || {e,i} (plus the SK block for the
// last party) to an external hash core and stores the digests in a commit RAM.
module sdith_commit_unit #(
    parameter string       PARAMETER_SET = "L1",
    parameter int unsigned LAMBDA        = (PARAMETER_SET == "L5") ? 256 :
                                           (PARAMETER_SET == "L3") ? 192 : 128,
    parameter int unsigned D_HYPERCUBE   = 8,
    parameter int unsigned K             = (PARAMETER_SET == "L5") ? 278 :
                                           (PARAMETER_SET == "L3") ? 193 : 126,
    parameter int unsigned WEIGHT        = (PARAMETER_SET == "L5") ? 150 :
                                           (PARAMETER_SET == "L3") ? 120 : 79,
    parameter int unsigned D_SPLIT       = (PARAMETER_SET == "L1") ? 1 : 2,
    parameter int unsigned SALT_SIZE     = 2 * LAMBDA,
    parameter int unsigned SK_SIZE       = 8 * (K + 2 * D_SPLIT * WEIGHT),
    parameter int unsigned BASE_LEN      = SALT_SIZE + LAMBDA + 32,
    parameter int unsigned LAST_LEN      = BASE_LEN + SK_SIZE,
    localparam int unsigned N            = 1 << D_HYPERCUBE,
    localparam int unsigned SEED_WORDS   = LAMBDA / 32,
    localparam int unsigned SALT_WORDS   = SALT_SIZE / 32,
    localparam int unsigned SK_WORDS     = (SK_SIZE + 31) / 32,
    localparam int unsigned BASE_WORDS   = BASE_LEN / 32,
    localparam int unsigned LAST_WORDS   = BASE_WORDS + SK_WORDS,
    localparam int unsigned CW           = $clog2(N * SEED_WORDS),
    localparam int unsigned SKW          = $clog2(SK_WORDS),
    localparam int unsigned HAW          = $clog2(LAST_WORDS),
    localparam int unsigned SAW          = $clog2(SALT_WORDS)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [7:0]     i_e,
    input  logic [31:0]    i_salt,
    input  logic [SAW-1:0] i_salt_addr,
    input  logic           i_salt_wr_en,
    output logic [CW-1:0]  o_seed_e_addr,
    output logic           o_seed_e_rd,
    input  logic [31:0]    i_seed_e,
    output logic [SKW-1:0] o_sk_addr,
    output logic           o_sk_rd_en,
    input  logic [31:0]    i_sk,
    input  logic           i_commit_rd,
    input  logic [CW-1:0]  i_commit_addr,
    output logic [31:0]    o_commit,
    output logic           o_hash_start,
    output logic [31:0]    o_hash_input_length,
    output logic [31:0]    o_hash_output_length,
    input  logic [HAW-1:0] i_hash_addr,
    input  logic           i_hash_rd_en,
    output logic [31:0]    o_hash_data_in,
    input  logic [31:0]    i_hash_data_out,
    input  logic           i_hash_data_out_valid,
    output logic           o_hash_data_out_ready,
    output logic           o_hash_force_done,
    input  logic           i_hash_force_done_ack,
    output logic           o_done
);

    localparam int unsigned SUBW     = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1;
    localparam int unsigned CTR_ADDR = SALT_WORDS + SEED_WORDS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED_RD,
        S_SEED_WAIT,
        S_HSTART,
        S_HOUT,
        S_FDONE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [D_HYPERCUBE-1:0] party_q;
    logic [SUBW-1:0]        sub_q;
    logic [31:0]            salt_q [SALT_WORDS];
    logic [31:0]            seed_q [SEED_WORDS];
    logic                   cap_v_q;
    logic [SUBW-1:0]        cap_idx_q;
    logic [31:0]            hash_len_q;
    logic [31:0]            hdata_q;
    logic                   sk_sel_q;
    logic [31:0]            commit_mem [N * SEED_WORDS];
    logic [31:0]            commit_q;

    logic                   is_last;
    logic                   sub_last;
    logic [CW-1:0]          slot_addr;
    logic                   commit_we;
    logic                   sk_hit;
    logic [31:0]            hash_word;

    assign is_last   = (party_q == '1);
    assign sub_last  = (sub_q == SUBW'(SEED_WORDS - 1));
    assign slot_addr = CW'(party_q) * CW'(SEED_WORDS) + CW'(sub_q);
    assign commit_we = (state_q == S_HOUT) && i_hash_data_out_valid;

    assign o_hash_output_length = 32'(LAMBDA);
    assign o_hash_input_length  = hash_len_q;
    assign o_commit             = commit_q;
    // The SK path bypasses the word register: the SK memory already adds one cycle.
    assign o_hash_data_in       = sk_sel_q ? i_sk : hdata_q;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and per-state strobes
    always_comb begin
        state_d               = state_q;
        o_seed_e_rd           = 1'b0;
        o_seed_e_addr         = '0;
        o_hash_start          = 1'b0;
        o_hash_data_out_ready = 1'b0;
        o_hash_force_done     = 1'b0;
        o_done                = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_SEED_RD;
            end
            S_SEED_RD: begin
                o_seed_e_rd   = 1'b1;
                o_seed_e_addr = slot_addr;
                if (sub_last) state_d = S_SEED_WAIT;
            end
            S_SEED_WAIT: state_d = S_HSTART;
            S_HSTART: begin
                o_hash_start = 1'b1;
                state_d      = S_HOUT;
            end
            S_HOUT: begin
                o_hash_data_out_ready = 1'b1;
                if (i_hash_data_out_valid && sub_last) state_d = S_FDONE;
            end
            S_FDONE: begin
                o_hash_force_done = 1'b1;
                if (i_hash_force_done_ack) state_d = is_last ? S_DONE : S_SEED_RD;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Party and word-within-party counters
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            party_q <= '0;
            sub_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    party_q <= '0;
                    sub_q   <= '0;
                end
                S_SEED_RD: sub_q <= sub_last ? '0 : sub_q + 1'b1;
                S_HOUT: begin
                    if (i_hash_data_out_valid) sub_q <= sub_last ? '0 : sub_q + 1'b1;
                end
                S_FDONE: begin
                    if (i_hash_force_done_ack && !is_last) party_q <= party_q + 1'b1;
                end
                S_DONE: party_q <= '0;
                default: ;
            endcase
        end
    end

    // Input length is latched once per party, just before the start pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst)                       hash_len_q <= '0;
        else if (state_q == S_SEED_WAIT)  hash_len_q <= is_last ? 32'(LAST_LEN) : 32'(BASE_LEN);
    end

    // Salt register file, writable at any time
    always_ff @(posedge i_clk) begin
        if (i_salt_wr_en) salt_q[i_salt_addr] <= i_salt;
    end

    // Track which seed word the 1-cycle-latency memory returns next
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cap_v_q   <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            cap_v_q   <= (state_q == S_SEED_RD);
            cap_idx_q <= sub_q;
        end
    end

    // Seed word capture
    always_ff @(posedge i_clk) begin
        if (cap_v_q) seed_q[cap_idx_q] <= i_seed_e;
    end

    // Hash input word map and SK read forwarding
    always_comb begin
        hash_word  = '0;
        sk_hit     = is_last && (i_hash_addr >= HAW'(BASE_WORDS)) &&
                     (i_hash_addr < HAW'(LAST_WORDS));
        o_sk_rd_en = i_hash_rd_en && sk_hit;
        o_sk_addr  = sk_hit ? SKW'(i_hash_addr - HAW'(BASE_WORDS)) : '0;
        if (i_hash_addr < HAW'(SALT_WORDS))
            hash_word = salt_q[i_hash_addr[SAW-1:0]];
        else if (i_hash_addr < HAW'(CTR_ADDR))
            hash_word = seed_q[SUBW'(i_hash_addr - HAW'(SALT_WORDS))];
        else if (i_hash_addr == HAW'(CTR_ADDR))
            hash_word = {8'h00, i_e, 16'(party_q)};
    end

    // Registered hash input word
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            hdata_q  <= '0;
            sk_sel_q <= 1'b0;
        end else begin
            sk_sel_q <= i_hash_rd_en && sk_hit;
            if (i_hash_rd_en) hdata_q <= hash_word;
        end
    end

    // Commit RAM write port
    always_ff @(posedge i_clk) begin
        if (commit_we) commit_mem[slot_addr] <= i_hash_data_out;
    end

    // Commit RAM read port (read-before-write on address collision)
    always_ff @(posedge i_clk) begin
        if (!i_rst)           commit_q <= '0;
        else if (i_commit_rd) commit_q <= commit_mem[i_commit_addr];
    end

endmodule

// File: tb/tb_sdith_commit_unit.sv
// Self-checking bench for sdith_commit_unit: emulates the hash core, seed and
// SK memories, and compares every hashed word and digest against a model.
module tb_sdith_commit_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [7:0]  i_e;
    logic [31:0] i_salt;
    logic [2:0]  i_salt_addr;
    logic        i_salt_wr_en;
    logic [9:0]  o_seed_e_addr;
    logic        o_seed_e_rd;
    logic [31:0] i_seed_e;
    logic [6:0]  o_sk_addr;
    logic        o_sk_rd_en;
    logic [31:0] i_sk;
    logic        i_commit_rd;
    logic [9:0]  i_commit_addr;
    logic [31:0] o_commit;
    logic        o_hash_start;
    logic [31:0] o_hash_input_length;
    logic [31:0] o_hash_output_length;
    logic [6:0]  i_hash_addr;
    logic        i_hash_rd_en;
    logic [31:0] o_hash_data_in;
    logic [31:0] i_hash_data_out;
    logic        i_hash_data_out_valid;
    logic        o_hash_data_out_ready;
    logic        o_hash_force_done;
    logic        i_hash_force_done_ack;
    logic        o_done;

    always #5 i_clk = ~i_clk;

    sdith_commit_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_e(i_e),
        .i_salt(i_salt), .i_salt_addr(i_salt_addr), .i_salt_wr_en(i_salt_wr_en),
        .o_seed_e_addr(o_seed_e_addr), .o_seed_e_rd(o_seed_e_rd), .i_seed_e(i_seed_e),
        .o_sk_addr(o_sk_addr), .o_sk_rd_en(o_sk_rd_en), .i_sk(i_sk),
        .i_commit_rd(i_commit_rd), .i_commit_addr(i_commit_addr), .o_commit(o_commit),
        .o_hash_start(o_hash_start), .o_hash_input_length(o_hash_input_length),
        .o_hash_output_length(o_hash_output_length), .i_hash_addr(i_hash_addr),
        .i_hash_rd_en(i_hash_rd_en), .o_hash_data_in(o_hash_data_in),
        .i_hash_data_out(i_hash_data_out), .i_hash_data_out_valid(i_hash_data_out_valid),
        .o_hash_data_out_ready(o_hash_data_out_ready), .o_hash_force_done(o_hash_force_done),
        .i_hash_force_done_ack(i_hash_force_done_ack), .o_done(o_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt, start_cnt, ack_cnt, done_ack_snap;

    logic [31:0] salt_m [8];
    logic [31:0] seed_m [1024];
    logic [31:0] sk_m   [71];
    logic [7:0]  e_val;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: hash input word a of party p, straight from the word map
    function automatic logic [31:0] exp_word(input int p, input int a);
        if (a < 8)   return salt_m[a];
        if (a < 12)  return seed_m[p * 4 + (a - 8)];
        if (a == 12) return {8'h00, e_val, 8'h00, 8'(p)};
        return sk_m[a - 13];
    endfunction

    // Digest returned by the emulated hash core
    function automatic logic [31:0] dig(input int run, input int p, input int k);
        return {8'(run), 8'(p), 8'h5a, 8'(k)};
    endfunction

    // Seed and SK memories, one-cycle read latency
    always @(posedge i_clk) begin
        if (o_seed_e_rd) i_seed_e <= seed_m[o_seed_e_addr];
        if (o_sk_rd_en)  i_sk     <= sk_m[o_sk_addr];
    end

    // Event counters
    always @(negedge i_clk) begin
        if (o_done) begin
            done_cnt++;
            done_ack_snap = ack_cnt;
        end
        if (o_hash_start) start_cnt++;
    end

    // Emulated hash core serving all 256 parties of one run
    task automatic hash_run(input int run);
        bit got;
        bit hit;
        int fd;
        int delay;
        int nw;
        for (int p = 0; p < 256; p++) begin
            got = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge i_clk);
                if (o_hash_start) begin
                    got = 1'b1;
                    break;
                end
                if (run == 2 && p == 100) i_start = (c == 2);
            end
            i_start = 1'b0;
            check_eq("hash_start_seen", 32'(got), 32'd1);
            if (!got) return;
            check_eq("in_len", o_hash_input_length, (p == 255) ? 32'd2688 : 32'd416);
            check_eq("out_len", o_hash_output_length, 32'd128);
            nw = (p == 255) ? 84 : 13;
            for (int a = 0; a < nw; a++) begin
                i_hash_addr  = 7'(a);
                i_hash_rd_en = 1'b1;
                #1;
                if (a >= 13) begin
                    check_eq("sk_rd_en", 32'(o_sk_rd_en), 32'd1);
                    check_eq("sk_addr", 32'(o_sk_addr), 32'(a - 13));
                end else begin
                    check_eq("sk_rd_idle", 32'(o_sk_rd_en), 32'd0);
                end
                @(negedge i_clk);
                i_hash_rd_en = 1'b0;
                check_eq("hash_word", o_hash_data_in, exp_word(p, a));
            end
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge i_clk);
                check_eq("out_ready", 32'(o_hash_data_out_ready), 32'd1);
                i_hash_data_out       = dig(run, p, k);
                i_hash_data_out_valid = 1'b1;
                if (run == 2) begin
                    i_commit_rd   = 1'b1;
                    i_commit_addr = 10'(p * 4 + k);
                end
                @(negedge i_clk);
                i_hash_data_out_valid = 1'b0;
                i_commit_rd           = 1'b0;
                if (run == 2) check_eq("commit_old_on_write", o_commit, dig(1, p, k));
            end
            delay = (run == 2 && p == 3) ? 20 : int'($urandom_range(1, 3));
            fd  = 0;
            hit = 1'b0;
            for (int c = 0; c < 200 && !hit; c++) begin
                if (o_hash_force_done) begin
                    fd++;
                    if (fd == delay) begin
                        i_hash_force_done_ack = 1'b1;
                        ack_cnt++;
                        hit = 1'b1;
                    end
                end else if (fd > 0) begin
                    break;
                end
                if (!hit) @(negedge i_clk);
            end
            check_eq("force_done_held", 32'(fd), 32'(delay));
            @(negedge i_clk);
            i_hash_force_done_ack = 1'b0;
            check_eq("force_done_drop", 32'(o_hash_force_done), 32'd0);
            if (!hit) return;
        end
    endtask

    initial begin
        int plist [4];
        i_rst = 1'b0; i_start = 1'b0; i_e = '0; i_salt = '0; i_salt_addr = '0;
        i_salt_wr_en = 1'b0; i_seed_e = '0; i_sk = '0; i_commit_rd = 1'b0;
        i_commit_addr = '0; i_hash_addr = '0; i_hash_rd_en = 1'b0;
        i_hash_data_out = '0; i_hash_data_out_valid = 1'b0; i_hash_force_done_ack = 1'b0;
        done_cnt = 0; start_cnt = 0; ack_cnt = 0; done_ack_snap = -1;

        repeat (10) @(negedge i_clk);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_hash_start", 32'(o_hash_start), 32'd0);
        check_eq("rst_seed_rd", 32'(o_seed_e_rd), 32'd0);
        check_eq("rst_force_done", 32'(o_hash_force_done), 32'd0);
        check_eq("rst_in_len", o_hash_input_length, 32'd0);
        check_eq("rst_commit", o_commit, 32'd0);
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        check_eq("idle_done", 32'(o_done), 32'd0);
        check_eq("idle_hash_start", 32'(o_hash_start), 32'd0);
        check_eq("idle_seed_rd", 32'(o_seed_e_rd), 32'd0);
        check_eq("idle_force_done", 32'(o_hash_force_done), 32'd0);

        for (int run = 1; run <= 2; run++) begin
            for (int i = 0; i < 1024; i++) seed_m[i] = $urandom;
            for (int i = 0; i < 71; i++)   sk_m[i]   = $urandom;
            for (int i = 0; i < 8; i++)    salt_m[i] = (run == 1) ? 32'd0 : $urandom;
            e_val = (run == 1) ? 8'd1 : 8'($urandom_range(2, 255));
            i_e   = e_val;
            for (int w = 0; w < 8; w++) begin
                i_salt_addr  = 3'(w);
                i_salt       = salt_m[w];
                i_salt_wr_en = 1'b1;
                @(negedge i_clk);
            end
            i_salt_wr_en  = 1'b0;
            done_cnt      = 0;
            start_cnt     = 0;
            ack_cnt       = 0;
            done_ack_snap = -1;
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
            hash_run(run);
            for (int c = 0; c < 20 && done_cnt == 0; c++) @(negedge i_clk);
            check_eq("done_pulses", 32'(done_cnt), 32'd1);
            check_eq("hash_starts", 32'(start_cnt), 32'd256);
            check_eq("done_after_acks", 32'(done_ack_snap), 32'd256);
            repeat (30) @(negedge i_clk);
            check_eq("no_restart", 32'(done_cnt), 32'd1);
            check_eq("idle_after_run", 32'(o_seed_e_rd), 32'd0);

            plist[0] = 0; plist[1] = 17; plist[2] = 255; plist[3] = int'($urandom_range(1, 254));
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < 4; k++) begin
                    i_commit_rd   = 1'b1;
                    i_commit_addr = 10'(plist[j] * 4 + k);
                    @(negedge i_clk);
                    i_commit_rd = 1'b0;
                    check_eq("commit_read", o_commit, dig(run, plist[j], k));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
